// File: rtl/i2c_host_arbiter.sv
// rtl/i2c_host_arbiter.sv - per-transaction round-robin owner of one shared I2C bus
// Losing hosts are held off by stretching SCL low in their view of the bus.
module i2c_host_arbiter #(
  parameter int NumHosts    = 2,
  parameter int IdleTimeout = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumHosts-1:0] host_scl_o_i,
  input  logic [NumHosts-1:0] host_scl_en_i,
  input  logic [NumHosts-1:0] host_sda_o_i,
  input  logic [NumHosts-1:0] host_sda_en_i,
  output logic [NumHosts-1:0] host_scl_i_o,
  output logic [NumHosts-1:0] host_sda_i_o,
  input  logic                bus_scl_i,
  input  logic                bus_sda_i,
  output logic                bus_scl_o,
  output logic                bus_scl_en_o,
  output logic                bus_sda_o,
  output logic                bus_sda_en_o,
  output logic [NumHosts-1:0] grant_o,
  output logic                busy_o
);

  localparam int PtrW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int CntW = $clog2(IdleTimeout);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

  state_e              r_state, w_state_nx;
  logic [NumHosts-1:0] r_grant, w_grant_nx;
  logic [PtrW-1:0]     r_ptr, w_ptr_nx;
  logic [CntW-1:0]     r_cnt, w_cnt_nx;
  logic                r_start_seen, w_start_nx;

  logic [1:0]          r_scl_sync, r_sda_sync;
  logic                r_scl_q, r_sda_q;
  logic                w_scl_s, w_sda_s;

  logic [NumHosts-1:0] w_scl_low, w_sda_low, w_req;
  logic                w_found;
  logic [PtrW-1:0]     w_win_idx, w_idx;
  logic                w_gnt_drive, w_idle_cyc, w_start_cond, w_stop_cond, w_timeout;
  logic                w_gnt_scl_low, w_gnt_sda_low;

  // Synchronizers idle high so reset never looks like a START or STOP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], bus_scl_i};
      r_sda_sync <= {r_sda_sync[0], bus_sda_i};
      r_scl_q    <= r_scl_sync[1];
      r_sda_q    <= r_sda_sync[1];
    end
  end

  assign w_scl_s = r_scl_sync[1];
  assign w_sda_s = r_sda_sync[1];

  assign w_scl_low = host_scl_en_i & ~host_scl_o_i;
  assign w_sda_low = host_sda_en_i & ~host_sda_o_i;
  assign w_req     = w_scl_low | w_sda_low;

  assign w_gnt_drive  = |(r_grant & w_req);
  assign w_idle_cyc   = w_scl_s & w_sda_s & ~w_gnt_drive;
  assign w_start_cond = w_scl_s & r_scl_q & r_sda_q & ~w_sda_s;
  assign w_stop_cond  = w_scl_s & r_scl_q & ~r_sda_q & w_sda_s;
  assign w_timeout    = w_idle_cyc && (r_cnt == CntW'(IdleTimeout - 1));

  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_idx     = '0;
    for (int i = 1; i <= NumHosts; i++) begin
      w_idx = PtrW'((int'(r_ptr) + i) % NumHosts);
      if (!w_found && w_req[w_idx]) begin
        w_found   = 1'b1;
        w_win_idx = w_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_ptr        <= PtrW'(NumHosts - 1);
      r_cnt        <= '0;
      r_start_seen <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_grant      <= w_grant_nx;
      r_ptr        <= w_ptr_nx;
      r_cnt        <= w_cnt_nx;
      r_start_seen <= w_start_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_start_nx = r_start_seen;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nx = ST_GRANTED;
          w_grant_nx = {{(NumHosts-1){1'b0}}, 1'b1} << w_win_idx;
          w_ptr_nx   = w_win_idx;
          w_cnt_nx   = '0;
          w_start_nx = 1'b0;
        end
      end
      ST_GRANTED: begin
        if (w_start_cond) begin
          w_start_nx = 1'b1;
        end
        w_cnt_nx = w_idle_cyc ? r_cnt + CntW'(1) : '0;
        if ((w_stop_cond && r_start_seen) || w_timeout) begin
          w_state_nx = ST_IDLE;
          w_grant_nx = '0;
          w_cnt_nx   = '0;
          w_start_nx = 1'b0;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_grant_nx = '0;
      end
    endcase
  end

  // Pads are open-drain: enable only when the owner pulls a line low.
  assign w_gnt_scl_low = |(r_grant & w_scl_low);
  assign w_gnt_sda_low = |(r_grant & w_sda_low);
  assign bus_scl_en_o  = w_gnt_scl_low;
  assign bus_sda_en_o  = w_gnt_sda_low;
  assign bus_scl_o     = |(r_grant & host_scl_o_i) & ~w_gnt_scl_low;
  assign bus_sda_o     = |(r_grant & host_sda_o_i) & ~w_gnt_sda_low;

  assign host_scl_i_o = (|r_grant) ? (r_grant & {NumHosts{bus_scl_i}}) : {NumHosts{bus_scl_i}};
  assign host_sda_i_o = {NumHosts{bus_sda_i}};

  assign grant_o = r_grant;
  assign busy_o  = (r_state == ST_GRANTED);

endmodule
